// File: rtl/dvp_axis_pkg.sv
// rtl/dvp_axis_pkg.sv - shared types for the DVP to AXI4-Stream video bridge
package dvp_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DROP   = 2'd3
    } state_e;

    // Framing tag carried next to each pixel; the pixel field is added where PIXEL_W is known
    typedef struct packed {
        logic sof;
        logic eol;
    } beat_tag_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // A write into a full FIFO is still taken when the head leaves in the same cycle
    always_comb begin
        pop      = rd_ready && (count_q != '0);
        push     = wr_valid && ((count_q != CW'(DEPTH)) || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/dvp_axis_bridge.sv
// rtl/dvp_axis_bridge.sv - byte-serial camera stream to AXI4-Stream video with SOF/EOL framing
module dvp_axis_bridge
    import dvp_axis_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int BPP        = 2,
    parameter  int H_ACTIVE   = 640,
    parameter  int V_ACTIVE   = 480,
    parameter  int FIFO_DEPTH = 16,
    localparam int PIXEL_W    = DATA_W * BPP
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               in_valid,
    input  logic               in_vsync,
    input  logic               in_href,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               enable,
    input  logic               clear_err,
    output logic [PIXEL_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               frame_done,
    output logic               overflow,
    output logic               size_err
);

    localparam int PC_W = $clog2(H_ACTIVE + 1);
    localparam int LC_W = $clog2(V_ACTIVE + 1);
    localparam int BC_W = cnt_w(BPP);
    localparam int FC_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [PIXEL_W-1:0] pixel;
        beat_tag_t          tag;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    state_e             state_q, state_d;
    logic               vs_q, vs_d, hr_q, hr_d;
    logic [PC_W-1:0]    pixel_cnt_q, pixel_cnt_d;
    logic [LC_W-1:0]    line_cnt_q, line_cnt_d;
    logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic               sof_pend_q, sof_pend_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic               size_err_q, size_err_d;

    logic               vs_rise, vs_fall, hr_fall;
    logic               push, accept, size_set, ovf_set;
    entry_t             push_entry, rd_entry;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               fifo_rd_valid;
    logic [FC_W-1:0]    fifo_count;

    assign vs_rise = in_vsync && !vs_q;
    assign vs_fall = !in_vsync && vs_q;
    assign hr_fall = !in_href && hr_q;
    assign accept  = (fifo_count != FC_W'(FIFO_DEPTH)) || (m_axis_tready && fifo_rd_valid);

    always_comb begin
        state_d      = state_q;
        vs_d         = vs_q;
        hr_d         = hr_q;
        pixel_cnt_d  = pixel_cnt_q;
        line_cnt_d   = line_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        sof_pend_d   = sof_pend_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        push_entry   = '0;
        size_set     = 1'b0;
        ovf_set      = 1'b0;

        if (in_valid) begin
            vs_d = in_vsync;
            hr_d = in_href;
            case (state_q)
                ST_IDLE: begin
                    if (vs_rise) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (vs_fall) begin
                        state_d     = enable ? ST_ACTIVE : ST_IDLE;
                        pixel_cnt_d = '0;
                        line_cnt_d  = '0;
                        byte_cnt_d  = '0;
                        sof_pend_d  = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (vs_rise) begin
                        state_d      = ST_SYNC;
                        frame_done_d = 1'b1;
                        size_set     = (line_cnt_q != LC_W'(V_ACTIVE));
                        pixel_cnt_d  = '0;
                        line_cnt_d   = '0;
                        byte_cnt_d   = '0;
                    end else if (in_href) begin
                        shift_d = (shift_q << DATA_W) | PIXEL_W'(in_data);
                        if (byte_cnt_q == BC_W'(BPP - 1)) begin
                            byte_cnt_d = '0;
                            // Pixels past the nominal line width are dropped, not wrapped
                            if (pixel_cnt_q < PC_W'(H_ACTIVE)) begin
                                push_entry.pixel   = shift_d;
                                push_entry.tag.sof = sof_pend_q;
                                push_entry.tag.eol = (pixel_cnt_q == PC_W'(H_ACTIVE - 1));
                                pixel_cnt_d        = pixel_cnt_q + PC_W'(1);
                                if (accept) begin
                                    push       = 1'b1;
                                    sof_pend_d = 1'b0;
                                end else begin
                                    ovf_set = 1'b1;
                                    state_d = ST_DROP;
                                end
                            end else begin
                                size_set = 1'b1;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + BC_W'(1);
                        end
                    end else if (hr_fall) begin
                        size_set    = (pixel_cnt_q != PC_W'(H_ACTIVE)) || (byte_cnt_q != '0);
                        pixel_cnt_d = '0;
                        byte_cnt_d  = '0;
                        if (line_cnt_q != LC_W'(V_ACTIVE)) begin
                            line_cnt_d = line_cnt_q + LC_W'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (vs_rise) state_d = ST_SYNC;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        overflow_d = ovf_set  ? 1'b1 : (clear_err ? 1'b0 : overflow_q);
        size_err_d = size_set ? 1'b1 : (clear_err ? 1'b0 : size_err_q);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            vs_q         <= 1'b0;
            hr_q         <= 1'b0;
            pixel_cnt_q  <= '0;
            line_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            sof_pend_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            size_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_d;
            hr_q         <= hr_d;
            pixel_cnt_q  <= pixel_cnt_d;
            line_cnt_q   <= line_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            sof_pend_q   <= sof_pend_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            size_err_q   <= size_err_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (aresetn),
        .wr_valid (push),
        .wr_data  (push_entry),
        .rd_valid (fifo_rd_valid),
        .rd_data  (fifo_rd_data),
        .rd_ready (m_axis_tready),
        .count    (fifo_count)
    );

    // Outputs read as zero while the buffer is empty so stale memory never shows
    assign rd_entry      = entry_t'(fifo_rd_data);
    assign m_axis_tvalid = fifo_rd_valid;
    assign m_axis_tdata  = fifo_rd_valid ? rd_entry.pixel   : '0;
    assign m_axis_tuser  = fifo_rd_valid ? rd_entry.tag.sof : 1'b0;
    assign m_axis_tlast  = fifo_rd_valid ? rd_entry.tag.eol : 1'b0;
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;
    assign size_err      = size_err_q;

endmodule

// File: tb/tb_dvp_axis_bridge.sv
// tb/tb_dvp_axis_bridge.sv - directed table-driven bench for dvp_axis_bridge
module tb_dvp_axis_bridge;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_valid = 1'b0, in_vsync = 1'b0, in_href = 1'b0;
    logic [7:0]  in_data = '0;
    logic        enable = 1'b1, clear_err = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tuser, m_axis_tlast;
    logic        frame_done, overflow, size_err;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    logic [17:0] bq[$];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_data;
        logic        exp_user;
        logic        exp_last;
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    dvp_axis_bridge #(
        .DATA_W(8), .BPP(2), .H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .in_valid(in_valid), .in_vsync(in_vsync), .in_href(in_href), .in_data(in_data),
        .enable(enable), .clear_err(clear_err),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .overflow(overflow), .size_err(size_err)
    );

    always @(negedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready)
            bq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (frame_done)
            fd_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] beat(input int idx);
        if (idx < bq.size()) return bq[idx];
        return 18'h3ffff;
    endfunction

    task automatic send_byte(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1; in_vsync = vs; in_href = hr; in_data = d;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int nb, input logic [7:0] start);
        for (int i = 0; i < nb; i++) send_byte(1'b0, 1'b1, start + 8'(i));
        send_byte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic table_frame();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) begin
                send_byte(1'b0, 1'b1, vt[l*4+p].b0);
                send_byte(1'b0, 1'b1, vt[l*4+p].b1);
            end
            send_byte(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic check_table(input string tag, input int base);
        logic [17:0] b;
        chk({tag, " beats"}, 32'(bq.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            b = beat(base + i);
            chk($sformatf("%s data[%0d]", tag, i), 32'(b[15:0]), 32'(vt[i].exp_data));
            chk($sformatf("%s user[%0d]", tag, i), 32'(b[17]), 32'(vt[i].exp_user));
            chk($sformatf("%s last[%0d]", tag, i), 32'(b[16]), 32'(vt[i].exp_last));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        aresetn = 1'b0; in_valid = 1'b0; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
    endtask

    int base, fdb;
    logic [17:0] b;

    initial begin
        vt[0] = '{8'h01, 8'h02, 16'h0102, 1'b1, 1'b0};
        vt[1] = '{8'h03, 8'h04, 16'h0304, 1'b0, 1'b0};
        vt[2] = '{8'h05, 8'h06, 16'h0506, 1'b0, 1'b0};
        vt[3] = '{8'h07, 8'h08, 16'h0708, 1'b0, 1'b1};
        vt[4] = '{8'h09, 8'h0a, 16'h090a, 1'b0, 1'b0};
        vt[5] = '{8'h0b, 8'h0c, 16'h0b0c, 1'b0, 1'b0};
        vt[6] = '{8'h0d, 8'h0e, 16'h0d0e, 1'b0, 1'b0};
        vt[7] = '{8'h0f, 8'h10, 16'h0f10, 1'b0, 1'b1};

        // reset state
        #12;
        chk("rst tvalid", 32'(m_axis_tvalid), 0);
        chk("rst tdata", 32'(m_axis_tdata), 0);
        chk("rst tuser", 32'(m_axis_tuser), 0);
        chk("rst tlast", 32'(m_axis_tlast), 0);
        chk("rst frame_done", 32'(frame_done), 0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst size_err", 32'(size_err), 0);
        @(posedge clk); #1 aresetn = 1'b1;

        // nominal frame
        base = bq.size(); fdb = fd_cnt;
        vs_pulse(); table_frame(); vs_pulse(); idle(10);
        check_table("t1", base);
        chk("t1 frame_done", 32'(fd_cnt - fdb), 1);
        chk("t1 overflow", 32'(overflow), 0);
        chk("t1 size_err", 32'(size_err), 0);

        // overflow with stalled sink
        do_reset();
        m_axis_tready = 1'b0;
        base = bq.size(); fdb = fd_cnt;
        vs_pulse(); table_frame();
        idle(1);
        chk("t2 hold tvalid", 32'(m_axis_tvalid), 1);
        chk("t2 hold tdata", 32'(m_axis_tdata), 32'h0102);
        chk("t2 hold tuser", 32'(m_axis_tuser), 1);
        idle(3);
        chk("t2 stable tdata", 32'(m_axis_tdata), 32'h0102);
        chk("t2 overflow", 32'(overflow), 1);
        vs_pulse(); idle(2);
        chk("t2 no frame_done", 32'(fd_cnt - fdb), 0);
        chk("t2 no beats", 32'(bq.size() - base), 0);
        m_axis_tready = 1'b1;
        idle(8);
        chk("t2 drained", 32'(bq.size() - base), 4);
        b = beat(base + 3);
        chk("t2 drained last", 32'(b[16]), 1);
        base = bq.size(); fdb = fd_cnt;
        table_frame(); vs_pulse(); idle(10);
        check_table("t2", base);
        chk("t2 frame_done", 32'(fd_cnt - fdb), 1);
        chk("t2 size_err", 32'(size_err), 0);

        // short line
        do_reset();
        base = bq.size();
        vs_pulse(); send_line(8, 8'h01); send_line(6, 8'h21); vs_pulse(); idle(10);
        chk("t3 beats", 32'(bq.size() - base), 7);
        b = beat(base + 3); chk("t3 last line0", 32'(b[16]), 1);
        b = beat(base + 4); chk("t3 data4", 32'(b[15:0]), 32'h2122);
        b = beat(base + 6); chk("t3 data6", 32'(b[15:0]), 32'h2526);
        chk("t3 no last", 32'(b[16]), 0);
        chk("t3 size_err", 32'(size_err), 1);
        chk("t3 overflow", 32'(overflow), 0);
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        chk("t3 cleared", 32'(size_err), 0);

        // odd byte count
        do_reset();
        base = bq.size();
        vs_pulse(); send_line(7, 8'h01); send_line(8, 8'h11); vs_pulse(); idle(10);
        chk("t4 beats", 32'(bq.size() - base), 7);
        b = beat(base + 2); chk("t4 data2", 32'(b[15:0]), 32'h0506);
        chk("t4 no last", 32'(b[16]), 0);
        b = beat(base + 3); chk("t4 data3", 32'(b[15:0]), 32'h1112);
        b = beat(base + 6); chk("t4 data6", 32'(b[15:0]), 32'h1718);
        chk("t4 last6", 32'(b[16]), 1);
        chk("t4 size_err", 32'(size_err), 1);

        // enable sampled at frame start
        do_reset();
        enable = 1'b0;
        base = bq.size(); fdb = fd_cnt;
        vs_pulse(); send_line(8, 8'h01); enable = 1'b1; send_line(8, 8'h09);
        vs_pulse(); idle(4);
        chk("t5 no beats", 32'(bq.size() - base), 0);
        chk("t5 no frame_done", 32'(fd_cnt - fdb), 0);
        table_frame(); vs_pulse(); idle(10);
        check_table("t5", base);
        chk("t5 frame_done", 32'(fd_cnt - fdb), 1);

        // reset mid-line
        do_reset();
        m_axis_tready = 1'b0;
        vs_pulse();
        send_byte(1'b0, 1'b1, 8'h01);
        send_byte(1'b0, 1'b1, 8'h02);
        chk("t6 pre tvalid", 32'(m_axis_tvalid), 0);
        @(posedge clk); #1;
        chk("t6 latency tvalid", 32'(m_axis_tvalid), 1);
        send_byte(1'b0, 1'b1, 8'h03);
        send_byte(1'b0, 1'b1, 8'h04);
        @(posedge clk); #1 in_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("t6 rst tvalid", 32'(m_axis_tvalid), 0);
        chk("t6 rst tdata", 32'(m_axis_tdata), 0);
        @(posedge clk); #1 aresetn = 1'b1;
        m_axis_tready = 1'b1;
        base = bq.size();
        send_line(8, 8'h31); idle(5);
        chk("t6 no beats", 32'(bq.size() - base), 0);
        vs_pulse(); table_frame(); vs_pulse(); idle(10);
        check_table("t6", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
